// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and helpers for the ADC round-robin sequencer.
//   adc_seq_state_t : sequencer FSM state encoding (IDLE encodes as 0)
//   CHAN_W          : channel index width (fixed at 3, up to 8 channels)
//   MAX_CHANNELS    : width of the internal round mask
//   lowest_set()    : index of the lowest set bit of a channel mask
package adc_seq_pkg;

  localparam int CHAN_W       = 3;
  localparam int MAX_CHANNELS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DATA = 3'd3,
    EMIT      = 3'd4
  } adc_seq_state_t;

  // Returns 0 for an all-zero mask; callers test the mask for zero first.
  function automatic logic [CHAN_W-1:0] lowest_set(input logic [MAX_CHANNELS-1:0] mask);
    logic [CHAN_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) idx = CHAN_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_seq_rate_timer.sv
// adc_seq_rate_timer: sample-period down-counter.
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : counting enabled; while low the counter holds rate_div
//   reload     : force the counter back to rate_div (sequencer idle)
//   rate_div   : period is rate_div+1 cycles
//   tick       : one-cycle pulse each time the counter reaches 0
module adc_seq_rate_timer #(
  parameter int RATE_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      reload,
  input  logic [RATE_DIV_WIDTH-1:0] rate_div,
  output logic                      tick
);

  logic [RATE_DIV_WIDTH-1:0] count;

  // Tick is suppressed while reloading so a fresh start always waits a full period.
  assign tick = run && !reload && (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || reload || (count == '0)) begin
      count <= rate_div;
    end else begin
      count <= count - {{(RATE_DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer: round-robin conversion scheduler for the MCP3008 front end.
// Each sample period it issues one conversion per enabled channel in
// ascending order, tags the returned result with its channel and presents it
// as a one-cycle-valid stream.
//
// Handshake: conv_start is a one-cycle request with conv_chan valid in the
// same cycle; exactly one conversion is outstanding at a time. conv_valid is a
// one-cycle strobe honoured only while waiting for data. axiov is a one-cycle
// strobe with axiod/axio_chan; there is no back-pressure.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   run                   : level, sequencing enabled
//   chan_en               : per-channel enable mask, sampled at each period tick
//   rate_div              : sample period = rate_div+1 cycles
//   conv_start, conv_chan : conversion request to the ADC core
//   conv_valid, conv_data : ADC result
//   axiov, axiod, axio_chan : output sample stream
//   overrun               : sticky, a tick arrived while a round was unfinished
//   timeout_err           : sticky, conversion watchdog fired
//   state                 : current FSM state (debug)
//
// Build option: define ADC_SEQ_TIMEOUT_EN to add the WAIT_DATA watchdog
// (TIMEOUT_CYCLES). Without it WAIT_DATA waits indefinitely and timeout_err is 0.
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CHANNELS      = 8,
  parameter int SAMPLE_DATA_WIDTH = 10,
  parameter int RATE_DIV_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [NUM_CHANNELS-1:0]      chan_en,
  input  logic [RATE_DIV_WIDTH-1:0]    rate_div,
  output logic                         conv_start,
  output logic [CHAN_W-1:0]            conv_chan,
  input  logic                         conv_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0] conv_data,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic [CHAN_W-1:0]            axio_chan,
  output logic                         overrun,
  output logic                         timeout_err,
  output adc_seq_state_t               state
);

  logic                    tick;
  logic [MAX_CHANNELS-1:0] round_mask;
  logic [CHAN_W-1:0]       cur_chan;

  logic [MAX_CHANNELS-1:0] chan_en_ext;
  logic [MAX_CHANNELS-1:0] remaining;
  logic [CHAN_W-1:0]       first_sel;
  logic [CHAN_W-1:0]       next_sel;
  logic                    continue_round;
  adc_seq_state_t          after_state;

  adc_seq_rate_timer #(
    .RATE_DIV_WIDTH (RATE_DIV_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .reload   (state == IDLE),
    .rate_div (rate_div),
    .tick     (tick)
  );

  // Decisions shared by EMIT and the watchdog path: drop the finished channel
  // and either move to the next higher enabled channel or close the round.
  always_comb begin
    chan_en_ext                   = '0;
    chan_en_ext[NUM_CHANNELS-1:0] = chan_en;
    first_sel                     = lowest_set(chan_en_ext);
    remaining                     = round_mask & ~(8'b1 << cur_chan);
    next_sel                      = lowest_set(remaining);
    continue_round                = (remaining != '0) && run;
    if (continue_round)  after_state = ISSUE;
    else if (run)        after_state = WAIT_TICK;
    else                 after_state = IDLE;
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      round_mask  <= '0;
      cur_chan    <= '0;
      conv_start  <= 1'b0;
      conv_chan   <= '0;
      axiov       <= 1'b0;
      axiod       <= '0;
      axio_chan   <= '0;
      overrun     <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      conv_start <= 1'b0;
      axiov      <= 1'b0;

      // A tick during an active round is dropped; the round keeps going.
      if (tick && (state == ISSUE || state == WAIT_DATA || state == EMIT)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (run) state <= WAIT_TICK;
        end

        WAIT_TICK: begin
          if (!run) begin
            state <= IDLE;
          end else if (tick) begin
            round_mask <= chan_en_ext;
            if (chan_en_ext != '0) begin
              cur_chan   <= first_sel;
              conv_chan  <= first_sel;
              conv_start <= 1'b1;
              state      <= ISSUE;
            end
          end
        end

        ISSUE: begin
          state <= WAIT_DATA;
`ifdef ADC_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        WAIT_DATA: begin
          if (conv_valid) begin
            axiov     <= 1'b1;
            axiod     <= conv_data;
            axio_chan <= cur_chan;
            state     <= EMIT;
          end
`ifdef ADC_SEQ_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            // Abandon this channel silently and carry on as if it had emitted.
            timeout_err <= 1'b1;
            round_mask  <= remaining;
            state       <= after_state;
            if (continue_round) begin
              cur_chan   <= next_sel;
              conv_chan  <= next_sel;
              conv_start <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        EMIT: begin
          round_mask <= remaining;
          state      <= after_state;
          if (continue_round) begin
            cur_chan   <= next_sel;
            conv_chan  <= next_sel;
            conv_start <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: bench for adc_sequencer. The reference model predicts the
// channel order of every round from the enable mask (ascending set bits) and
// the sample stream from the data the ADC model hands back.
module tb_adc_sequencer;
  import adc_seq_pkg::*;

  localparam int SDW = 10;
  localparam int EW  = CHAN_W + SDW;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                run = 1'b0;
  logic [7:0]          chan_en = '0;
  logic [15:0]         rate_div = '0;
  logic                conv_start;
  logic [CHAN_W-1:0]   conv_chan;
  logic                conv_valid;
  logic [SDW-1:0]      conv_data;
  logic                axiov;
  logic [SDW-1:0]      axiod;
  logic [CHAN_W-1:0]   axio_chan;
  logic                overrun;
  logic                timeout_err;
  adc_seq_state_t      state;

  adc_sequencer #(
    .NUM_CHANNELS      (8),
    .SAMPLE_DATA_WIDTH (SDW),
    .RATE_DIV_WIDTH    (16),
    .TIMEOUT_CYCLES    (64)
  ) dut (
    .clk (clk), .rst_n (rst_n), .run (run), .chan_en (chan_en), .rate_div (rate_div),
    .conv_start (conv_start), .conv_chan (conv_chan),
    .conv_valid (conv_valid), .conv_data (conv_data),
    .axiov (axiov), .axiod (axiod), .axio_chan (axio_chan),
    .overrun (overrun), .timeout_err (timeout_err), .state (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [CHAN_W-1:0] pred_q[$];   // channels the model expects to be issued, in order
  logic [EW-1:0]     exp_q[$];    // {chan, data} samples expected on the output
  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_axiov = 0;
  int valid_cyc = -10;
  int lat = 1;
  logic [7:0] mute = '0;          // channels the ADC model never answers

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // ---------------- ADC model (driver) ----------------
  initial begin : adc_model
    logic [CHAN_W-1:0] p;
    logic [CHAN_W-1:0] ch;
    logic [SDW-1:0]    d;
    bit                aborted;
    conv_valid = 1'b0;
    conv_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && conv_start) begin
        n_start++;
        if (pred_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_conv_start: got chan %0d, required no request", conv_chan);
        end else begin
          p = pred_q.pop_front();
          check("conv_chan", 32'(conv_chan), 32'(p));
        end
        if (!mute[conv_chan]) begin
          ch = conv_chan;
          aborted = 1'b0;
          for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (!rst_n) aborted = 1'b1;
          end
          if (!aborted) begin
            d = SDW'($urandom);
            conv_valid = 1'b1;
            conv_data  = d;
            valid_cyc  = cyc;
            exp_q.push_back({ch, d});
            @(negedge clk);
            conv_valid = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && axiov) begin
        n_axiov++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_axiov: got chan %0d data %0d, required no sample", axio_chan, axiod);
        end else begin
          e = exp_q.pop_front();
          check("axio_chan", 32'(axio_chan), 32'(e[EW-1:SDW]));
          check("axiod", 32'(axiod), 32'(e[SDW-1:0]));
          check("axiov_latency", cyc, valid_cyc + 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    mute  = '0;
    repeat (3) @(negedge clk);
    pred_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_segment(input string name, input logic [7:0] mask, input int rd,
                             input int l, input int rounds, input bit exp_ovr,
                             input bit exp_ovr_first);
    int k, target, seen, budget;
    do_reset();
    chan_en  = mask;
    rate_div = 16'(rd);
    lat      = l;
    k = 0;
    for (int i = 0; i < 8; i++) if (mask[i]) k++;
    for (int r = 0; r < rounds; r++)
      for (int i = 0; i < 8; i++) if (mask[i]) pred_q.push_back(CHAN_W'(i));
    target = rounds * k;
    budget = rounds * (rd + 1 + k * (l + 3)) * 2 + 100;
    seen = 0;
    run = 1'b1;
    for (int t = 0; t < budget && seen < target; t++) begin
      @(negedge clk);
      if (axiov) begin
        seen++;
        if (seen == 1) check({name, "_overrun_at_first_sample"}, 32'(overrun), 32'(exp_ovr_first));
        if (seen == target) run = 1'b0;
      end
    end
    run = 1'b0;
    check({name, "_samples"}, seen, target);
    repeat (5) @(negedge clk);
    check({name, "_state_idle"}, 32'(state), 32'(IDLE));
    check({name, "_pending_issues"}, pred_q.size(), 0);
    check({name, "_pending_samples"}, exp_q.size(), 0);
    check({name, "_overrun"}, 32'(overrun), 32'(exp_ovr));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string      name;
    logic [7:0] mask;
    int         rd;
    int         l;
    int         rounds;
    bit         exp_ovr;
    bit         exp_ovr_first;
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int s0, a0, t;
    bit got;
    vecs[0] = '{"mask85_slow",  8'b1000_0101, 199, 20, 3, 1'b0, 1'b0};
    vecs[1] = '{"mask85_fast",  8'b1000_0101, 30,  20, 3, 1'b1, 1'b0};
    vecs[2] = '{"rate_div_0",   8'h01,        0,   1,  4, 1'b1, 1'b1};
    vecs[3] = '{"all_channels", 8'hFF,        100, 2,  2, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_conv_start", 32'(conv_start), 0);
    check("reset_axiov", 32'(axiov), 0);
    check("reset_state", 32'(state), 32'(IDLE));
    check("reset_overrun", 32'(overrun), 0);
    rst_n = 1'b1;

    // Table vectors
    for (int v = 0; v < 4; v++)
      run_segment(vecs[v].name, vecs[v].mask, vecs[v].rd, vecs[v].l,
                  vecs[v].rounds, vecs[v].exp_ovr, vecs[v].exp_ovr_first);

    // Randomized segments with a comfortable period: no overrun allowed
    for (int r = 0; r < 4; r++) begin
      logic [7:0] m;
      int l, k, rd;
      m = 8'($urandom_range(1, 255));
      l = $urandom_range(1, 12);
      k = 0;
      for (int i = 0; i < 8; i++) if (m[i]) k++;
      rd = k * (l + 3) + $urandom_range(2, 40);
      run_segment("random", m, rd, l, $urandom_range(2, 3), 1'b0, 1'b0);
    end

    // Reset asserted while waiting for data
    do_reset();
    chan_en = 8'h01; rate_div = 16'd10; lat = 3; mute = 8'h01;
    pred_q.push_back(3'd0);
    run = 1'b1;
    got = 1'b0;
    for (t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (state == WAIT_DATA) got = 1'b1;
    end
    check("reach_wait_data", 32'(got), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    check("async_reset_state", 32'(state), 32'(IDLE));
    check("async_reset_outputs", {conv_start, axiov, overrun, timeout_err, conv_chan, axio_chan}, 0);
    check("async_reset_axiod", 32'(axiod), 0);
    repeat (3) @(negedge clk);
    mute = '0;
    pred_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    s0 = n_start; a0 = n_axiov;
    repeat (30) @(negedge clk);
    check("post_reset_no_axiov", n_axiov - a0, 0);
    check("post_reset_no_start", n_start - s0, 0);
    check("post_reset_idle", 32'(state), 32'(IDLE));

    // Empty mask for five periods, stray conv_valid, then enable channel 4
    do_reset();
    chan_en = 8'h00; rate_div = 16'd19; lat = 3;
    s0 = n_start; a0 = n_axiov;
    run = 1'b1;
    repeat (37) @(negedge clk);
    conv_data = 10'h155; conv_valid = 1'b1;
    @(negedge clk);
    conv_valid = 1'b0;
    repeat (62) @(negedge clk);
    check("empty_mask_no_start", n_start - s0, 0);
    check("empty_mask_no_axiov", n_axiov - a0, 0);
    check("empty_mask_overrun", 32'(overrun), 0);
    repeat (7) @(negedge clk);
    chan_en = 8'h10;
    pred_q.push_back(3'd4);
    got = 1'b0;
    for (t = 0; t < 22 && !got; t++) begin
      @(negedge clk);
      if (conv_start) got = 1'b1;
    end
    check("ch4_start_within_period", 32'(got), 1);
    got = 1'b0;
    for (t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (axiov) begin got = 1'b1; run = 1'b0; end
    end
    run = 1'b0;
    check("ch4_sampled", 32'(got), 1);
    repeat (5) @(negedge clk);
    check("ch4_pending", pred_q.size() + exp_q.size(), 0);

    // run dropped during the channel 2 conversion of mask 0x0F
    do_reset();
    chan_en = 8'h0F; rate_div = 16'd200; lat = 10;
    pred_q.push_back(3'd0); pred_q.push_back(3'd1); pred_q.push_back(3'd2);
    s0 = n_start; a0 = n_axiov;
    run = 1'b1;
    got = 1'b0;
    for (t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (conv_start && conv_chan == 3'd2) got = 1'b1;
    end
    check("ch2_issued", 32'(got), 1);
    @(negedge clk);
    run = 1'b0;
    repeat (40) @(negedge clk);
    check("run_drop_samples", n_axiov - a0, 3);
    check("run_drop_starts", n_start - s0, 3);
    check("run_drop_state", 32'(state), 32'(IDLE));
    check("run_drop_pending", pred_q.size() + exp_q.size(), 0);

`ifdef ADC_SEQ_TIMEOUT_EN
    // Channel 1 never answers: watchdog fires, channel 0 continues
    do_reset();
    chan_en = 8'h03; rate_div = 16'd300; lat = 5; mute = 8'h02;
    pred_q.push_back(3'd0); pred_q.push_back(3'd1); pred_q.push_back(3'd0);
    a0 = n_axiov;
    run = 1'b1;
    got = 1'b0;
    for (t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (conv_start && conv_chan == 3'd1) got = 1'b1;
    end
    check("ch1_issued", 32'(got), 1);
    repeat (63) @(negedge clk);
    check("timeout_not_yet", 32'(timeout_err), 0);
    repeat (3) @(negedge clk);
    check("timeout_fired", 32'(timeout_err), 1);
    check("timeout_no_ch1_sample", n_axiov - a0, 1);
    got = 1'b0;
    for (t = 0; t < 700 && !got; t++) begin
      @(negedge clk);
      if (axiov) begin got = 1'b1; run = 1'b0; end
    end
    run = 1'b0;
    check("ch0_next_round", 32'(got), 1);
    repeat (5) @(negedge clk);
    check("timeout_pending", pred_q.size() + exp_q.size(), 0);
    check("timeout_state", 32'(state), 32'(IDLE));
`else
    // Without the watchdog an unanswered conversion waits indefinitely
    do_reset();
    chan_en = 8'h01; rate_div = 16'd50; lat = 3; mute = 8'h01;
    pred_q.push_back(3'd0);
    a0 = n_axiov;
    run = 1'b1;
    repeat (1500) @(negedge clk);
    check("no_watchdog_state", 32'(state), 32'(WAIT_DATA));
    check("no_watchdog_err", 32'(timeout_err), 0);
    check("no_watchdog_axiov", n_axiov - a0, 0);
    check("no_watchdog_pending", pred_q.size(), 0);
    run = 1'b0;
`endif

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL global_timeout: got still running, required finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
